// File: rtl/jstk_poll_sched_if.sv
// Bundle between the joystick poll scheduler, the SPI controller and the game logic.
// The master side is the scheduler: it issues requests and publishes the decoded sample.
interface jstk_poll_sched_if;
  logic        en;
  logic [1:0]  led;
  logic        ss;
  logic [39:0] jstk_dout;
  logic        snd_rec;
  logic [7:0]  din;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [2:0]  btn;
  logic        sample_valid;
  logic [1:0]  dir;
  logic        dir_valid;
  logic        timeout_err;

  modport master (
    input  en, led, ss, jstk_dout,
    output snd_rec, din, x, y, btn, sample_valid, dir, dir_valid, timeout_err
  );

  modport slave (
    output en, led, ss, jstk_dout,
    input  snd_rec, din, x, y, btn, sample_valid, dir, dir_valid, timeout_err
  );
endinterface

// File: rtl/jstk_poll_sched.sv
// Periodic joystick poll scheduler: requests one SPI transaction per period,
// latches X/Y/buttons and turns the stick position into a snake direction.
module jstk_poll_sched #(
  parameter int unsigned POLL_CYCLES    = 6667,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned DEAD_LO        = 300,
  parameter int unsigned DEAD_HI        = 724
) (
  input  logic               CLK,
  input  logic               RST,
  jstk_poll_sched_if.master  bus
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] XFER   = 3'd2;
  localparam logic [2:0] LATCH  = 3'd3;
  localparam logic [2:0] DECODE = 3'd4;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]    DLO       = 10'(DEAD_LO);
  localparam logic [9:0]    DHI       = 10'(DEAD_HI);

  logic [2:0]    state;
  logic [PW-1:0] pollCnt;
  logic [TW-1:0] toCnt;
  logic          sndRec;
  logic [7:0]    dinReg;
  logic [9:0]    xReg;
  logic [9:0]    yReg;
  logic [2:0]    btnReg;
  logic [1:0]    dirReg;
  logic          sampleValid;
  logic          dirValid;
  logic          timeoutErr;

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [10:0]        adx;
  logic [10:0]        ady;
  logic [1:0]         cand;
  logic               dead;
  logic               accept;
  logic               toHit;
  logic               unusedDoutBits;

  function automatic logic [10:0] absS(input logic signed [10:0] v);
    return (v < 11'sd0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic inBand(input logic [9:0] v);
    return (v >= DLO) && (v <= DHI);
  endfunction

  // Direction candidate from the latched sample; the dominant axis wins, ties go to X.
  always_comb begin
    dx     = $signed({1'b0, xReg}) - 11'sd512;
    dy     = $signed({1'b0, yReg}) - 11'sd512;
    adx    = absS(dx);
    ady    = absS(dy);
    dead   = inBand(xReg) && inBand(yReg);
    cand   = DIR_RIGHT;
    if (adx >= ady) cand = (dx > 11'sd0) ? DIR_RIGHT : DIR_LEFT;
    else            cand = (dy > 11'sd0) ? DIR_UP    : DIR_DOWN;
    // Opposite directions differ only in the MSB, so a 180-degree turn is dir ^ 2'b10.
    accept = !dead && (cand != dirReg) && (cand != (dirReg ^ 2'b10));
  end

  assign toHit          = (toCnt == TO_LAST);
  assign unusedDoutBits = ^{bus.jstk_dout[31:26], bus.jstk_dout[15:10], bus.jstk_dout[7:3]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      pollCnt     <= POLL_LOAD;
      toCnt       <= '0;
      sndRec      <= 1'b0;
      dinReg      <= 8'h80;
      xReg        <= '0;
      yReg        <= '0;
      btnReg      <= '0;
      dirReg      <= DIR_RIGHT;
      sampleValid <= 1'b0;
      dirValid    <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      sampleValid <= 1'b0;
      dirValid    <= 1'b0;
      timeoutErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            if (pollCnt == '0) begin
              state  <= REQ;
              sndRec <= 1'b1;
              dinReg <= {6'b100000, bus.led};
              toCnt  <= '0;
            end else begin
              pollCnt <= pollCnt - 1'b1;
            end
          end
        end
        REQ, XFER: begin
          if (toHit) begin
            state      <= IDLE;
            pollCnt    <= POLL_LOAD;
            sndRec     <= 1'b0;
            timeoutErr <= 1'b1;
          end else begin
            toCnt <= toCnt + 1'b1;
            if (state == REQ && !bus.ss) begin
              state <= XFER;
            end else if (state == XFER && bus.ss) begin
              // Dropping the request here lets the controller leave its Done state.
              state  <= LATCH;
              sndRec <= 1'b0;
            end
          end
        end
        LATCH: begin
          xReg   <= {bus.jstk_dout[25:24], bus.jstk_dout[39:32]};
          yReg   <= {bus.jstk_dout[9:8],   bus.jstk_dout[23:16]};
          btnReg <= bus.jstk_dout[2:0];
          state  <= DECODE;
        end
        DECODE: begin
          sampleValid <= 1'b1;
          if (accept) begin
            dirReg   <= cand;
            dirValid <= 1'b1;
          end
          state   <= IDLE;
          pollCnt <= POLL_LOAD;
        end
        default: begin
          state   <= IDLE;
          pollCnt <= POLL_LOAD;
          sndRec  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.snd_rec      = sndRec;
  assign bus.din          = dinReg;
  assign bus.x            = xReg;
  assign bus.y            = yReg;
  assign bus.btn          = btnReg;
  assign bus.sample_valid = sampleValid;
  assign bus.dir          = dirReg;
  assign bus.dir_valid    = dirValid;
  assign bus.timeout_err  = timeoutErr;

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Self-checking bench for jstk_poll_sched: a task-driven SPI controller stand-in
// plus a compass-style direction model.
module tb_jstk_poll_sched;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] refDir;
  logic [9:0] refX;
  logic [9:0] refY;
  logic [2:0] refBtn;
  logic [1:0] curLed;

  jstk_poll_sched_if bus ();

  jstk_poll_sched #(
    .POLL_CYCLES    (8),
    .TIMEOUT_CYCLES (16),
    .DEAD_LO        (300),
    .DEAD_HI        (724)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Directions as compass indices: 0 up, 1 right, 2 down, 3 left; opposite = +2 mod 4.
  task automatic predict(input logic [9:0] px, input logic [9:0] py,
                         output logic [1:0] nd, output bit chg);
    int dx, dy, ax, ay, c;
    bit dz;
    dx = int'(px) - 512;
    dy = int'(py) - 512;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    dz = (px >= 300) && (px <= 724) && (py >= 300) && (py <= 724);
    chg = 1'b0;
    nd  = refDir;
    if (!dz) begin
      if (ax >= ay) c = (dx > 0) ? 1 : 3;
      else          c = (dy > 0) ? 0 : 2;
      if (c != int'(refDir) && ((c + 2) % 4) != int'(refDir)) begin
        chg = 1'b1;
        nd  = 2'(c);
      end
    end
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (bus.snd_rec === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_wait: snd_rec=%b after 200 cycles, required 1", bus.snd_rec);
    end else begin
      checks++;
      if (bus.din !== {6'b100000, curLed}) begin
        errors++;
        $display("FAIL din: got %h, required %h", bus.din, {6'b100000, curLed});
      end
    end
  endtask

  task automatic finishPoll(input logic [9:0] px, input logic [9:0] py, input logic [2:0] pb,
                            input bit dropEn, input string tag);
    logic [39:0] d;
    logic [1:0]  nd;
    bit          chg;
    repeat ($urandom_range(0, 3)) tick();
    bus.ss = 1'b0;
    tick();
    if (dropEn) bus.en = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    d[31:0]  = $urandom;
    d[39:32] = px[7:0];
    d[25:24] = px[9:8];
    d[23:16] = py[7:0];
    d[9:8]   = py[9:8];
    d[2:0]   = pb;
    bus.jstk_dout = d;
    bus.ss        = 1'b1;
    predict(px, py, nd, chg);
    tick();
    checks++;
    if (bus.snd_rec !== 1'b0) begin
      errors++;
      $display("FAIL %s_sndrec_fall: got %b, required 0", tag, bus.snd_rec);
    end
    tick();
    checks++;
    if ({bus.x, bus.y, bus.btn} !== {px, py, pb}) begin
      errors++;
      $display("FAIL %s_xyb: got x=%0d y=%0d btn=%0d, required x=%0d y=%0d btn=%0d",
               tag, bus.x, bus.y, bus.btn, px, py, pb);
    end
    bus.jstk_dout = {$urandom, 8'($urandom)};
    tick();
    checks++;
    if (bus.sample_valid !== 1'b1 || bus.dir_valid !== chg || bus.dir !== nd) begin
      errors++;
      $display("FAIL %s_decode: got sv=%b dv=%b dir=%b, required sv=1 dv=%b dir=%b",
               tag, bus.sample_valid, bus.dir_valid, bus.dir, chg, nd);
    end
    tick();
    checks++;
    if (bus.sample_valid !== 1'b0 || bus.dir_valid !== 1'b0 || {bus.x, bus.y, bus.btn} !== {px, py, pb}) begin
      errors++;
      $display("FAIL %s_pulse_end: got sv=%b dv=%b x=%0d, required sv=0 dv=0 x=%0d",
               tag, bus.sample_valid, bus.dir_valid, bus.x, px);
    end
    refDir = nd;
    refX   = px;
    refY   = py;
    refBtn = pb;
  endtask

  task automatic poll(input logic [9:0] px, input logic [9:0] py, input logic [2:0] pb,
                      input string tag);
    bit ok;
    curLed  = 2'($urandom);
    bus.led = curLed;
    waitReq(ok);
    if (ok) finishPoll(px, py, pb, 1'b0, tag);
  endtask

  task automatic test_reset();
    int n;
    RST = 1'b1;
    bus.en = 1'b0;
    bus.ss = 1'b1;
    bus.led = 2'b00;
    bus.jstk_dout = '0;
    repeat (3) tick();
    checks++;
    if (bus.snd_rec !== 1'b0 || bus.din !== 8'h80 || bus.dir !== 2'b01) begin
      errors++;
      $display("FAIL reset_ctrl: got snd_rec=%b din=%h dir=%b, required 0 80 01",
               bus.snd_rec, bus.din, bus.dir);
    end
    checks++;
    if ({bus.x, bus.y, bus.btn, bus.sample_valid, bus.dir_valid, bus.timeout_err} !== 26'd0) begin
      errors++;
      $display("FAIL reset_data: got x=%0d y=%0d btn=%0d pulses=%b%b%b, required all 0",
               bus.x, bus.y, bus.btn, bus.sample_valid, bus.dir_valid, bus.timeout_err);
    end
    refDir = 2'b01; refX = '0; refY = '0; refBtn = '0;
    RST = 1'b0;
    bus.en = 1'b1;
    curLed = 2'b10;
    bus.led = curLed;
    n = 0;
    for (int i = 1; i <= 50 && n == 0; i++) begin
      tick();
      if (bus.snd_rec === 1'b1) n = i;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL first_req_latency: got %0d cycles, required 8", n);
    end
    checks++;
    if (bus.din !== 8'h82) begin
      errors++;
      $display("FAIL first_din: got %h, required 82", bus.din);
    end
  endtask

  task automatic test_first_sample();
    if (bus.snd_rec === 1'b1) finishPoll(10'd800, 10'd512, 3'd1, 1'b0, "first");
  endtask

  task automatic test_direction();
    poll(10'd512, 10'd1000, 3'd0, "up");
    poll(10'd100, 10'd512, 3'd2, "left");
    poll(10'd1000, 10'd512, 3'd4, "reverse");
  endtask

  task automatic test_deadzone();
    poll(10'd600, 10'd400, 3'd7, "deadzone");
    poll(10'd300, 10'd724, 3'd3, "dead_edge");
  endtask

  task automatic test_tie();
    poll(10'd812, 10'd212, 3'd0, "tie_inhibit");
    poll(10'd512, 10'd1000, 3'd0, "to_up");
    poll(10'd812, 10'd212, 3'd5, "tie");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      poll(10'($urandom), 10'($urandom), 3'($urandom), "rand");
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    curLed  = 2'($urandom);
    bus.led = curLed;
    waitReq(ok);
    if (ok) begin
      n = 0;
      for (int i = 1; i <= 40 && n == 0; i++) begin
        tick();
        if (bus.timeout_err === 1'b1) n = i;
      end
      checks++;
      if (n != 16 || bus.snd_rec !== 1'b0) begin
        errors++;
        $display("FAIL timeout: got pulse after %0d cycles snd_rec=%b, required 16 and 0",
                 n, bus.snd_rec);
      end
      checks++;
      if ({bus.x, bus.y, bus.btn, bus.dir} !== {refX, refY, refBtn, refDir}) begin
        errors++;
        $display("FAIL timeout_hold: got x=%0d y=%0d btn=%0d dir=%b, required %0d %0d %0d %b",
                 bus.x, bus.y, bus.btn, bus.dir, refX, refY, refBtn, refDir);
      end
      tick();
      checks++;
      if (bus.timeout_err !== 1'b0 || bus.sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse_end: got terr=%b sv=%b, required 0 0",
                 bus.timeout_err, bus.sample_valid);
      end
    end
    poll(10'($urandom), 10'($urandom), 3'($urandom), "after_to");
  endtask

  task automatic test_en_drop();
    bit ok;
    bit seen;
    curLed  = 2'($urandom);
    bus.led = curLed;
    waitReq(ok);
    if (ok) finishPoll(10'd20, 10'd500, 3'd6, 1'b1, "en_drop");
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (bus.snd_rec !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL en_park: got snd_rec=1 while en=0, required 0");
    end
    bus.en = 1'b1;
    poll(10'($urandom), 10'($urandom), 3'($urandom), "en_back");
  endtask

  task automatic test_rst_xfer();
    bit ok;
    curLed  = 2'($urandom);
    bus.led = curLed;
    waitReq(ok);
    if (ok) begin
      bus.ss = 1'b0;
      tick();
      tick();
      RST = 1'b1;
      tick();
      checks++;
      if (bus.snd_rec !== 1'b0 || bus.dir !== 2'b01 || bus.din !== 8'h80) begin
        errors++;
        $display("FAIL rst_xfer: got snd_rec=%b dir=%b din=%h, required 0 01 80",
                 bus.snd_rec, bus.dir, bus.din);
      end
      bus.ss = 1'b1;
      RST = 1'b0;
      refDir = 2'b01; refX = '0; refY = '0; refBtn = '0;
    end
    poll(10'd512, 10'd10, 3'd1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_direction();
    test_deadzone();
    test_tie();
    test_random();
    test_timeout();
    test_en_drop();
    test_rst_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
